// File: rtl/bfu_r2_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W on packed {imag, real} words.
// Optional build macro BFU_SAT_EN: saturate out-of-range results instead of wrapping.
module bfu_r2_pipe #(
  parameter int DW      = 16,
  parameter int TW_FRAC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] a,
  input  logic [2*DW-1:0] b,
  input  logic [2*DW-1:0] tw,
  input  logic            conj,
  input  logic            scale,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] x,
  output logic [2*DW-1:0] y,
  output logic            ovf
);

  localparam int PW = 2*DW + 2;
  localparam int SW = 2*DW + 3;

  function automatic logic signed [PW-1:0] sext_p(input logic [DW-1:0] v);
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sext_s(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  // A value fits in signed DW when every bit from DW-1 upward equals the sign.
  function automatic logic fits(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] h;
    h = v >>> (DW-1);
    return (h == '0) || (h == '1);
  endfunction

  function automatic logic [DW-1:0] reduce(input logic signed [SW-1:0] v);
    logic [DW-1:0] lim;
`ifdef BFU_SAT_EN
    lim = v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    lim = v[DW-1:0];
`endif
    return fits(v) ? v[DW-1:0] : lim;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  logic            s1_valid, s1_conj, s1_scale;
  logic [2*DW-1:0] s1_a, s1_b, s1_tw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_conj  <= 1'b0;
      s1_scale <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tw    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_conj  <= conj;
      s1_scale <= scale;
      s1_a     <= a;
      s1_b     <= b;
      s1_tw    <= tw;
    end
  end

  // Complex product at PW bits so that negating the most negative twiddle is exact.
  logic signed [PW-1:0] br, bi, wr, wi, wi_c, pr_full, pi_full;

  always_comb begin
    br      = sext_p(s1_b[DW-1:0]);
    bi      = sext_p(s1_b[2*DW-1:DW]);
    wr      = sext_p(s1_tw[DW-1:0]);
    wi      = sext_p(s1_tw[2*DW-1:DW]);
    wi_c    = s1_conj ? -wi : wi;
    pr_full = br * wr - bi * wi_c;
    pi_full = br * wi_c + bi * wr;
  end

  logic                 s2_valid, s2_scale;
  logic [2*DW-1:0]      s2_a;
  logic signed [PW-1:0] s2_pr, s2_pi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a     <= '0;
      s2_pr    <= '0;
      s2_pi    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_a     <= s1_a;
      s2_pr    <= pr_full >>> TW_FRAC;
      s2_pi    <= pi_full >>> TW_FRAC;
    end
  end

  logic signed [SW-1:0] ar3, ai3, pr3, pi3, xr, xi, yr, yi;
  logic                 ovf_next;

  always_comb begin
    ar3 = sext_s(s2_a[DW-1:0]);
    ai3 = sext_s(s2_a[2*DW-1:DW]);
    pr3 = {s2_pr[PW-1], s2_pr};
    pi3 = {s2_pi[PW-1], s2_pi};
    xr  = ar3 + pr3;
    xi  = ai3 + pi3;
    yr  = ar3 - pr3;
    yi  = ai3 - pi3;
    if (s2_scale) begin
      xr = xr >>> 1;
      xi = xi >>> 1;
      yr = yr >>> 1;
      yi = yi >>> 1;
    end
    ovf_next = !fits(xr) || !fits(xi) || !fits(yr) || !fits(yi);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      x         <= {reduce(xi), reduce(xr)};
      y         <= {reduce(yi), reduce(yr)};
      ovf       <= ovf_next;
    end
  end

endmodule
